aes_encipher_block: RTL and testbench

Sequential AES encipher datapath. It iterates the initial, main and final rounds over a 128-bit block for AES-128 or AES-256. SubBytes is time-multiplexed over a parametrised number of S-box lanes, trading area against latency. It sits between the core control/API layer and the key memory: it requests round keys by index and returns the finished ciphertext with a ready handshake.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_encipher_block.sv | 158 +++++++++++++++
 tb/tb_aes_encipher_block.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES encipher datapath.
// Contents: key-length selector values, round counts per key length, the
// controller state encoding, and byte-lane helpers (GF(2^8) doubling/tripling,
// ShiftRows, MixColumns). A 128-bit block holds byte 0 in bits [127:120],
// and bytes are numbered column-major (byte k = row k%4, column k/4).
package aes_pkg;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_INIT  = 2'd1,
        CTRL_SUB   = 2'd2,
        CTRL_ROUND = 2'd3
    } ctrl_state_t;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // One column, row 0 in the top byte.
    function automatic logic [31:0] mixcolumn(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = col;
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixcolumn(s[127:96]), mixcolumn(s[95:64]),
                mixcolumn(s[63:32]),  mixcolumn(s[31:0])};
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational lookup.
// Ports:
//   addr : input byte
//   data : substituted byte
module aes_sbox (
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data = SBOX[addr];

endmodule

// File: rtl/aes_encipher_block.sv
// Sequential AES-128/AES-256 encipher datapath with time-multiplexed SubBytes.
//
// state      | meaning
// -----------+------------------------------------------------------------
// CTRL_IDLE  | ready=1, waiting for next; new_block holds the last result
// CTRL_INIT  | initial AddRoundKey with round key 0
// CTRL_SUB   | SubBytes, SBOX_LANES bytes per cycle, 16/SBOX_LANES cycles
// CTRL_ROUND | ShiftRows, MixColumns (skipped in last round), AddRoundKey
//
// Ports:
//   clk        : clock, all state on the rising edge
//   reset      : asynchronous active-high reset
//   next       : start pulse, accepted only while ready=1
//   keylen     : 0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds)
//   round      : round-key index requested from key memory
//   round_key  : key for index round, combinational from key memory
//   block      : plaintext, sampled when next is accepted
//   new_block  : ciphertext, updated only on the completion edge
//   ready      : 1 = idle
module aes_encipher_block
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam int GROUPS = 16 / SBOX_LANES;
    localparam int LW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(GROUPS - 1);

    ctrl_state_t   state_q, state_d;
    logic [127:0]  data_q, data_d;
    logic [LW-1:0] lane_ctr, lane_d;
    logic          keylen_q, keylen_d;
    logic [3:0]    round_d;
    logic          ready_d;
    logic [127:0]  new_block_d;

    logic [7:0]    sbox_in  [SBOX_LANES];
    logic [7:0]    sbox_out [SBOX_LANES];
    logic [127:0]  sub_data;
    logic [127:0]  round_data;
    logic [3:0]    nr;
    int            base;

    assign nr   = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
    assign base = int'(lane_ctr) * SBOX_LANES;

    // The active group of bytes is routed through the shared S-boxes and
    // written back in place; all other bytes pass through untouched.
    always_comb begin
        for (int g = 0; g < SBOX_LANES; g++) begin
            sbox_in[g] = data_q[127 - 8*(base + g) -: 8];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_sbox
        aes_sbox u_sbox (
            .addr (sbox_in[g]),
            .data (sbox_out[g])
        );
    end

    always_comb begin
        sub_data = data_q;
        for (int g = 0; g < SBOX_LANES; g++) begin
            sub_data[127 - 8*(base + g) -: 8] = sbox_out[g];
        end
    end

    always_comb begin
        round_data = shiftrows(data_q);
        if (round != nr) begin
            round_data = mixcolumns(round_data);
        end
        round_data = round_data ^ round_key;
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        lane_d      = lane_ctr;
        keylen_d    = keylen_q;
        round_d     = round;
        ready_d     = ready;
        new_block_d = new_block;
        case (state_q)
            CTRL_IDLE: begin
                if (next && ready) begin
                    data_d   = block;
                    keylen_d = keylen;
                    round_d  = 4'd0;
                    ready_d  = 1'b0;
                    state_d  = CTRL_INIT;
                end
            end
            CTRL_INIT: begin
                data_d  = data_q ^ round_key;
                round_d = 4'd1;
                lane_d  = '0;
                state_d = CTRL_SUB;
            end
            CTRL_SUB: begin
                data_d = sub_data;
                if (lane_ctr == LANE_LAST) begin
                    lane_d  = '0;
                    state_d = CTRL_ROUND;
                end else begin
                    lane_d = lane_ctr + 1'b1;
                end
            end
            CTRL_ROUND: begin
                data_d = round_data;
                lane_d = '0;
                if (round == nr) begin
                    new_block_d = round_data;
                    ready_d     = 1'b1;
                    round_d     = 4'd0;
                    state_d     = CTRL_IDLE;
                end else begin
                    round_d = round + 4'd1;
                    state_d = CTRL_SUB;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CTRL_IDLE;
            data_q    <= '0;
            lane_ctr  <= '0;
            keylen_q  <= 1'b0;
            round     <= 4'd0;
            ready     <= 1'b1;
            new_block <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            lane_ctr  <= lane_d;
            keylen_q  <= keylen_d;
            round     <= round_d;
            ready     <= ready_d;
            new_block <= new_block_d;
        end
    end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Scoreboarded bench for aes_encipher_block at SBOX_LANES = 1, 4 and 16.
// Index 0 = 1 lane, 1 = 4 lanes, 2 = 16 lanes. Round keys and expected
// ciphertext come from a byte-array AES model with a field-arithmetic S-box.
`timescale 1ns/1ps
module tb_aes_encipher_block;

    typedef struct {
        logic [127:0] ct;
        int           lat;
        string        name;
    } exp_t;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         keylen = 1'b0;
    logic [127:0] block  = '0;
    logic         nxt      [3];
    logic         rdy      [3];
    logic [3:0]   rnd      [3];
    logic [127:0] nb       [3];
    logic [127:0] rk       [3];
    logic         rdy_prev [3];
    int           last_acc [3];
    logic [127:0] act_sched  [3][16];
    logic [127:0] pend_sched [16];
    logic [7:0]   sbox_t     [256];
    exp_t         sb_q  [3][$];
    int           acc_q [3][$];
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    aes_encipher_block #(.SBOX_LANES(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .next(nxt[0]), .keylen(keylen), .round(rnd[0]),
        .round_key(rk[0]), .block(block), .new_block(nb[0]), .ready(rdy[0]));
    aes_encipher_block #(.SBOX_LANES(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .next(nxt[1]), .keylen(keylen), .round(rnd[1]),
        .round_key(rk[1]), .block(block), .new_block(nb[1]), .ready(rdy[1]));
    aes_encipher_block #(.SBOX_LANES(16)) u_dut_l16 (
        .clk(clk), .reset(reset), .next(nxt[2]), .keylen(keylen), .round(rnd[2]),
        .round_key(rk[2]), .block(block), .new_block(nb[2]), .ready(rdy[2]));

    // Key memory: each DUT sees the schedule captured when it accepted next.
    always_comb begin
        for (int i = 0; i < 3; i++) rk[i] = act_sched[i][rnd[i]];
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic int lanes_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            pend_sched[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] ct;
        for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8] ^ pend_sched[0][127 - 8*j -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int j = 0; j < 16; j++) s[j] = sbox_t[s[j]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = (r == nr) ? t[row + 4*c] :
                        gmul(8'h02, t[row + 4*c]) ^ gmul(8'h03, t[(row + 1) % 4 + 4*c]) ^
                        t[(row + 2) % 4 + 4*c] ^ t[(row + 3) % 4 + 4*c];
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ pend_sched[r][127 - 8*j -: 8];
        end
        for (int j = 0; j < 16; j++) ct[127 - 8*j -: 8] = s[j];
        return ct;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_blk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_idle(input logic [2:0] mask);
        int n;
        bit all_rdy;
        n = 0;
        forever begin
            @(negedge clk);
            all_rdy = 1'b1;
            for (int i = 0; i < 3; i++) if (mask[i] && rdy[i] !== 1'b1) all_rdy = 1'b0;
            if (all_rdy) return;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL wait_idle_timeout: mask %b still busy after %0d cycles", mask, n);
                return;
            end
        end
    endtask

    task automatic issue(input logic [2:0] mask, input logic [255:0] key, input logic kl,
                         input logic [127:0] pt, input logic [127:0] known, input bit use_known,
                         input string name);
        int nr;
        logic [127:0] ct;
        nr = kl ? 14 : 10;
        expand(key, kl);
        ct = use_known ? known : ref_encrypt(pt, nr);
        for (int i = 0; i < 3; i++)
            if (mask[i]) sb_q[i].push_back('{ct, 1 + nr*(16/lanes_of(i) + 1), name});
        @(negedge clk);
        block  = pt;
        keylen = kl;
        for (int i = 0; i < 3; i++) nxt[i] = mask[i];
        @(negedge clk);
        for (int i = 0; i < 3; i++) nxt[i] = 1'b0;
    endtask

    // ---------------- acceptance logger ----------------
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (nxt[i] && rdy[i]) begin
                    acc_q[i].push_back(cyc + 1);
                    last_acc[i] <= cyc + 1;
                    for (int j = 0; j < 16; j++) act_sched[i][j] <= pend_sched[j];
                end
            end
        end
    end

    // ---------------- completion monitor ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset && rdy[i] === 1'b1 && rdy_prev[i] === 1'b0) begin
                if (sb_q[i].size() == 0 || acc_q[i].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done dut%0d: got completion with %0d expected entries",
                             i, sb_q[i].size());
                end else begin
                    exp_t e;
                    int   a;
                    e = sb_q[i].pop_front();
                    a = acc_q[i].pop_front();
                    check_blk($sformatf("%s_dut%0d_ct", e.name, i), nb[i], e.ct);
                    check_int($sformatf("%s_dut%0d_latency", e.name, i), cyc - a, e.lat);
                end
            end
            rdy_prev[i] <= rdy[i];
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]   inv;
        logic [255:0] rkey;
        logic         rkl;
        logic [127:0] rpt;
        int           seq [$];
        int           last, gap, n, r0, done;
        bit           hold_ok;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 3; i++) nxt[i] = 1'b0;

        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_int($sformatf("reset_ready_dut%0d", i), int'(rdy[i]), 1);
        check_int("reset_round", int'(rnd[1]), 0);
        check_blk("reset_new_block", nb[1], '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(3'b010, {KEY_B, 128'h0}, 1'b0, PT_B, CT_B, 1'b1, "appb");
        wait_idle(3'b010);

        issue(3'b111, {KEY_C1, 128'h0}, 1'b0, PT_C, CT_C1, 1'b1, "c1");
        wait_idle(3'b111);

        issue(3'b010, KEY_C3, 1'b1, PT_C, CT_C3, 1'b1, "c3");
        last = -1; n = 0;
        while (rdy[1] !== 1'b1 && n < 300) begin
            if (int'(rnd[1]) != last) begin
                seq.push_back(int'(rnd[1]));
                last = int'(rnd[1]);
            end
            @(negedge clk);
            n++;
        end
        check_int("c3_round_count", seq.size(), 15);
        gap = -1;
        for (int k = 0; k < seq.size(); k++) if (seq[k] != k && gap < 0) gap = k;
        check_int("c3_round_first_gap", gap, -1);
        wait_idle(3'b010);

        issue(3'b010, {KEY_C1, 128'h0}, 1'b0, PT_C, CT_C1, 1'b1, "busy");
        repeat (9) @(negedge clk);
        r0 = int'(rnd[1]);
        block  = PT_B;
        nxt[1] = 1'b1;
        @(negedge clk);
        nxt[1] = 1'b0;
        check_int("busy_ready_low", int'(rdy[1]), 0);
        check_int("busy_round_kept", int'(int'(rnd[1]) >= r0 && rnd[1] != 4'd0), 1);
        wait_idle(3'b010);

        issue(3'b010, {KEY_B, 128'h0}, 1'b0, PT_B, CT_B, 1'b1, "aborted");
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_int("midreset_ready", int'(rdy[1]), 1);
        check_int("midreset_round", int'(rnd[1]), 0);
        check_blk("midreset_new_block", nb[1], '0);
        for (int i = 0; i < 3; i++) begin
            sb_q[i].delete();
            acc_q[i].delete();
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(3'b010, {KEY_B, 128'h0}, 1'b0, PT_B, CT_B, 1'b1, "post_reset");
        wait_idle(3'b010);

        // Back-to-back with next held high.
        expand({KEY_C1, 128'h0}, 1'b0);
        sb_q[1].push_back('{CT_C1, 51, "b2b_first"});
        @(negedge clk);
        block  = PT_C;
        keylen = 1'b0;
        nxt[1] = 1'b1;
        @(negedge clk);
        expand({KEY_B, 128'h0}, 1'b0);
        sb_q[1].push_back('{CT_B, 51, "b2b_second"});
        block = PT_B;
        n = 0;
        while (rdy[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_int("b2b_first_done_in_time", int'(n < 200), 1);
        done = cyc;
        @(negedge clk);
        check_int("b2b_restart_gap", last_acc[1] - done, 1);
        check_int("b2b_busy_again", int'(rdy[1]), 0);
        nxt[1] = 1'b0;
        hold_ok = 1'b1; n = 0;
        while (rdy[1] !== 1'b1 && n < 200) begin
            if (nb[1] !== CT_C1) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check_int("b2b_hold_first_result", int'(hold_ok), 1);
        wait_idle(3'b010);

        repeat (6) begin
            for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom;
            rkl = 1'($urandom_range(0, 1));
            rpt = {$urandom, $urandom, $urandom, $urandom};
            issue(3'b111, rkey, rkl, rpt, '0, 1'b0, "rand");
            wait_idle(3'b111);
        end

        @(negedge clk);
        check_int("scoreboard_drained", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
